// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package hazard_pkg;

  // Stall FSM states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // EX operand select encodings
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Producer/consumer address match; register 0 never matches.
  function automatic logic prod_match(input logic wr_en, input logic rd_is_zero,
                                      input logic addr_eq, input logic src_vld);
    return wr_en & ~rd_is_zero & addr_eq & src_vld;
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source compare: next EX operand select and load-use hit for one operand.
module fwd_src_cmp
  import hazard_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter bit IS_STORE_SRC = 1'b0
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_src_vld,
  input  logic             i_id_is_store,
  input  logic [REG_W-1:0] i_idex_rd,
  input  logic             i_idex_regwrite,
  input  logic             i_idex_memread,
  input  logic [REG_W-1:0] i_exmem_rd,
  input  logic             i_exmem_regwrite,
  output logic [1:0]       o_nxt_sel,
  output logic             o_lu_hit
);

  logic w_m_idex;
  logic w_m_exmem;
  logic w_store_data;

  assign w_m_idex  = prod_match(i_idex_regwrite, (i_idex_rd == '0),
                                (i_idex_rd == i_src), i_src_vld);
  assign w_m_exmem = prod_match(i_exmem_regwrite, (i_exmem_rd == '0),
                                (i_exmem_rd == i_src), i_src_vld);

  // Store data of a store behind a load is served MEM-to-MEM, so it never stalls.
  assign w_store_data = IS_STORE_SRC & i_id_is_store;

  // Youngest producer wins the select
  always_comb begin
    o_nxt_sel = FWD_NONE;
    if (w_m_idex)       o_nxt_sel = FWD_EXMEM;
    else if (w_m_exmem) o_nxt_sel = FWD_MEMWB;
  end

  assign o_lu_hit = i_idex_memread & w_m_idex & ~w_store_data;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_vld,
  input  logic                     id_is_store,
  input  logic [REG_W-1:0]         idex_rd,
  input  logic [REG_W-1:0]         exmem_rd,
  input  logic [REG_W-1:0]         memwb_rd,
  input  logic                     idex_regwrite,
  input  logic                     exmem_regwrite,
  input  logic                     memwb_regwrite,
  input  logic                     idex_memread,
  input  logic [REG_W-1:0]         exmem_rt,
  input  logic                     exmem_memwrite,
  input  logic                     mem_busy,
  input  logic                     cnt_clr,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     fwd_mem,
  output logic                     stall_fd,
  output logic                     flush_idex,
  output logic                     freeze,
  output logic [CNT_W-1:0]         lu_cnt,
  output logic [CNT_W-1:0]         mw_cnt
);

  logic [NUM_SRC-1:0][1:0] w_nxt_sel;
  logic [NUM_SRC-1:0]      w_lu_hit;
  logic                    w_load_use;
  logic                    w_stall;

  state_e                  r_state;
  logic [2*NUM_SRC-1:0]    r_fwd_sel;
  logic [CNT_W-1:0]        r_lu_cnt;
  logic [CNT_W-1:0]        r_mw_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_cmp #(
        .REG_W        (REG_W),
        .IS_STORE_SRC (gi == 1)
      ) u_cmp (
        .i_src            (id_src[gi*REG_W +: REG_W]),
        .i_src_vld        (id_src_vld[gi]),
        .i_id_is_store    (id_is_store),
        .i_idex_rd        (idex_rd),
        .i_idex_regwrite  (idex_regwrite),
        .i_idex_memread   (idex_memread),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_regwrite (exmem_regwrite),
        .o_nxt_sel        (w_nxt_sel[gi]),
        .o_lu_hit         (w_lu_hit[gi])
      );
    end
  endgenerate

  assign w_load_use = |w_lu_hit;
  // A frozen pipeline cannot advance, so the load-use bubble waits until the freeze ends.
  assign w_stall    = w_load_use & ~mem_busy;

  assign freeze     = mem_busy;
  assign stall_fd   = w_stall;
  assign flush_idex = w_stall;
  assign fwd_mem    = memwb_regwrite & exmem_memwrite & (memwb_rd != '0) &
                      (memwb_rd == exmem_rt);

  assign fwd_sel    = r_fwd_sel;
  assign lu_cnt     = r_lu_cnt;
  assign mw_cnt     = r_mw_cnt;

  // Operand select travels with the instruction into EX; a bubble carries no forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_fwd_sel <= '0;
    else if (mem_busy) r_fwd_sel <= r_fwd_sel;
    else if (w_stall)  r_fwd_sel <= '0;
    else               r_fwd_sel <= w_nxt_sel;
  end

  // Stall FSM: memory wait dominates, load-use stall is a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_busy)        r_state <= MEM_WAIT;
          else if (w_load_use) r_state <= LU_STALL;
          else                 r_state <= RUN;
        end
        LU_STALL: r_state <= mem_busy ? MEM_WAIT : RUN;
        MEM_WAIT: r_state <= mem_busy ? MEM_WAIT : RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  // Saturating stall counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
    end else if (cnt_clr) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if (w_stall && !(&r_lu_cnt))  r_lu_cnt <= r_lu_cnt + 1'b1;
      if (mem_busy && !(&r_mw_cnt)) r_mw_cnt <= r_mw_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with a scoreboard of expected EX selects.
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam int REG_W = 4;
  localparam int NUM_SRC = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_vld;
  logic                     id_is_store;
  logic [REG_W-1:0]         idex_rd, exmem_rd, memwb_rd, exmem_rt;
  logic                     idex_regwrite, exmem_regwrite, memwb_regwrite;
  logic                     idex_memread, exmem_memwrite, mem_busy, cnt_clr;
  logic [2*NUM_SRC-1:0]     fwd_sel, s_fwd_sel;
  logic                     fwd_mem, stall_fd, flush_idex, freeze;
  logic                     s_fwd_mem, s_stall_fd, s_flush_idex, s_freeze;
  logic [15:0]              lu_cnt, mw_cnt;
  logic [1:0]               s_lu_cnt, s_mw_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_is_store(id_is_store), .idex_rd(idex_rd), .exmem_rd(exmem_rd),
    .memwb_rd(memwb_rd), .idex_regwrite(idex_regwrite),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .idex_memread(idex_memread), .exmem_rt(exmem_rt),
    .exmem_memwrite(exmem_memwrite), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_sel), .fwd_mem(fwd_mem), .stall_fd(stall_fd),
    .flush_idex(flush_idex), .freeze(freeze), .lu_cnt(lu_cnt), .mw_cnt(mw_cnt)
  );

  // Narrow-counter instance on the same stimulus to reach saturation quickly
  hazard_forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_is_store(id_is_store), .idex_rd(idex_rd), .exmem_rd(exmem_rd),
    .memwb_rd(memwb_rd), .idex_regwrite(idex_regwrite),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .idex_memread(idex_memread), .exmem_rt(exmem_rt),
    .exmem_memwrite(exmem_memwrite), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .fwd_sel(s_fwd_sel), .fwd_mem(s_fwd_mem), .stall_fd(s_stall_fd),
    .flush_idex(s_flush_idex), .freeze(s_freeze), .lu_cnt(s_lu_cnt), .mw_cnt(s_mw_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    id_src = '0; id_src_vld = '0; id_is_store = 1'b0;
    idex_rd = '0; exmem_rd = '0; memwb_rd = '0; exmem_rt = '0;
    idex_regwrite = 1'b0; exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    idex_memread = 1'b0; exmem_memwrite = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // Advance one cycle and compare fwd_sel with the oldest scoreboard entry.
  task automatic step(input string tag);
    logic [3:0] e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_fwd_sel"}, 32'(fwd_sel), 32'(e));
    end
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    #12;
    // Reset state, combinational outputs live during reset
    chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    chk("rst_lu_cnt", 32'(lu_cnt), 32'd0);
    chk("rst_mw_cnt", 32'(mw_cnt), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(RUN));
    mem_busy = 1'b1; #1;
    chk("rst_freeze_follow", 32'(freeze), 32'd1);
    mem_busy = 1'b0; #1;
    chk("rst_freeze_low", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back ALU dependency
    idex_rd = 4'd3; idex_regwrite = 1'b1; id_src[3:0] = 4'd3; id_src_vld = 2'b01; #1;
    chk("alu_no_stall", 32'(stall_fd), 32'd0);
    sb_q.push_back(4'b0010); step("alu");

    // Two-ago dependency with ID/EX priority, then EX/MEM only
    clr_in();
    exmem_rd = 4'd5; exmem_regwrite = 1'b1; idex_rd = 4'd5; idex_regwrite = 1'b1;
    id_src[7:4] = 4'd5; id_src_vld = 2'b10;
    sb_q.push_back(4'b1000); step("prio");
    idex_regwrite = 1'b0;
    sb_q.push_back(4'b0100); step("exmem");

    // Register 0 never matches
    clr_in();
    idex_rd = 4'd0; idex_regwrite = 1'b1; idex_memread = 1'b1; id_src_vld = 2'b11; #1;
    chk("r0_no_stall", 32'(stall_fd), 32'd0);
    sb_q.push_back(4'b0000); step("r0");

    // Load-use: one stall cycle, then MEM/WB-path forward
    clr_in();
    idex_memread = 1'b1; idex_rd = 4'd4; idex_regwrite = 1'b1;
    id_src[3:0] = 4'd4; id_src_vld = 2'b01; #1;
    chk("lu_stall_fd", 32'(stall_fd), 32'd1);
    chk("lu_flush", 32'(flush_idex), 32'd1);
    sb_q.push_back(4'b0000); step("lu_bubble");
    chk("lu_state_stall", 32'(dut.r_state), 32'(LU_STALL));
    chk("lu_cnt_1", 32'(lu_cnt), 32'd1);
    idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = '0;
    exmem_rd = 4'd4; exmem_regwrite = 1'b1; #1;
    chk("lu_stall_once", 32'(stall_fd), 32'd0);
    sb_q.push_back(4'b0001); step("lu_fwd");
    chk("lu_state_run", 32'(dut.r_state), 32'(RUN));
    chk("lu_cnt_hold", 32'(lu_cnt), 32'd1);

    // Load then store data: no stall, later MEM-to-MEM forward
    clr_in();
    idex_memread = 1'b1; idex_rd = 4'd4; idex_regwrite = 1'b1;
    id_src[7:4] = 4'd4; id_src_vld = 2'b10; id_is_store = 1'b1; #1;
    chk("st_no_stall", 32'(stall_fd), 32'd0);
    sb_q.push_back(4'b1000); step("st_data");
    chk("st_state_run", 32'(dut.r_state), 32'(RUN));
    clr_in();
    memwb_rd = 4'd4; memwb_regwrite = 1'b1; exmem_rt = 4'd4; exmem_memwrite = 1'b1;
    id_src[3:0] = 4'd4; id_src_vld = 2'b01; #1;
    chk("fwd_mem_hit", 32'(fwd_mem), 32'd1);
    sb_q.push_back(4'b0000); step("memwb_no_sel");
    memwb_rd = 4'd0; exmem_rt = 4'd0; #1;
    chk("fwd_mem_r0", 32'(fwd_mem), 32'd0);

    // mem_busy for 3 cycles coinciding with load-use
    clr_in();
    idex_rd = 4'd3; idex_regwrite = 1'b1; id_src[3:0] = 4'd3; id_src_vld = 2'b01;
    sb_q.push_back(4'b0010); step("pre_busy");
    idex_memread = 1'b1; idex_rd = 4'd4; id_src[3:0] = 4'd4; mem_busy = 1'b1; #1;
    chk("busy_freeze", 32'(freeze), 32'd1);
    chk("busy_no_stall", 32'(stall_fd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(4'b0010); step("busy_hold");
      chk("busy_state", 32'(dut.r_state), 32'(MEM_WAIT));
    end
    chk("mw_cnt_3", 32'(mw_cnt), 32'd3);
    chk("s_mw_cnt_3", 32'(s_mw_cnt), 32'd3);
    mem_busy = 1'b0; #1;
    chk("post_busy_stall", 32'(stall_fd), 32'd1);
    chk("post_busy_nofrz", 32'(freeze), 32'd0);
    sb_q.push_back(4'b0000); step("post_busy_bubble");
    chk("lu_cnt_2", 32'(lu_cnt), 32'd2);
    idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = '0;
    exmem_rd = 4'd4; exmem_regwrite = 1'b1; #1;
    chk("post_busy_once", 32'(stall_fd), 32'd0);
    sb_q.push_back(4'b0001); step("post_busy_fwd");
    chk("post_busy_run", 32'(dut.r_state), 32'(RUN));

    // Clear wins over a simultaneous increment
    clr_in();
    idex_memread = 1'b1; idex_rd = 4'd6; idex_regwrite = 1'b1;
    id_src[3:0] = 4'd6; id_src_vld = 2'b01; cnt_clr = 1'b1;
    sb_q.push_back(4'b0000); step("clr");
    chk("clr_lu", 32'(lu_cnt), 32'd0);
    chk("clr_mw", 32'(mw_cnt), 32'd0);
    chk("clr_s_lu", 32'(s_lu_cnt), 32'd0);

    // Saturation of the narrow counter
    cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(4'b0000); step("sat");
    end
    chk("sat_s_lu", 32'(s_lu_cnt), 32'd3);
    chk("sat_lu", 32'(lu_cnt), 32'd4);

    // Reset pulse while in MEM_WAIT
    clr_in();
    idex_rd = 4'd3; idex_regwrite = 1'b1; id_src[3:0] = 4'd3; id_src_vld = 2'b01;
    sb_q.push_back(4'b0010); step("pre_rst");
    mem_busy = 1'b1;
    sb_q.push_back(4'b0010); step("rst_wait");
    chk("rst_wait_state", 32'(dut.r_state), 32'(MEM_WAIT));
    chk("rst_wait_mw", 32'(mw_cnt), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_state", 32'(dut.r_state), 32'(RUN));
    chk("mid_rst_sel", 32'(fwd_sel), 32'd0);
    chk("mid_rst_lu", 32'(lu_cnt), 32'd0);
    chk("mid_rst_mw", 32'(mw_cnt), 32'd0);
    chk("mid_rst_freeze", 32'(freeze), 32'd1);
    clr_in();
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.push_back(4'b0000); step("after_rst");
    chk("after_rst_state", 32'(dut.r_state), 32'(RUN));
    chk("after_rst_mw", 32'(mw_cnt), 32'd0);
    chk("after_rst_stall", 32'(stall_fd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter REG_W, default 4: register-address width.
REQ-003 Parameter NUM_SRC, default 2: source operands per instruction; source index 1 is the store-data operand.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_src  in  NUM_SRC*REG_W  decode-stage source addresses; source i at bits [i*REG_W +: REG_W]
- id_src_vld  in  NUM_SRC  per-source read enable
- id_is_store  in  1  decode instruction is a store
- idex_rd / exmem_rd / memwb_rd  in  REG_W each  destination addresses
- idex_regwrite / exmem_regwrite / memwb_regwrite  in  1 each  write enables
- idex_memread  in  1  EX instruction is a load
- exmem_rt  in  REG_W  store-data register in MEM
- exmem_memwrite  in  1  MEM instruction is a store
- mem_busy  in  1  data memory not ready; whole pipeline freezes
- cnt_clr  in  1  synchronous counter clear
- fwd_sel  out  2*NUM_SRC  registered per-source EX operand select
- fwd_mem  out  1  MEM-to-MEM store-data forward
- stall_fd  out  1  hold PC and IF/ID
- flush_idex  out  1  load ID/EX with a bubble
- freeze  out  1  hold all pipeline registers
- lu_cnt / mw_cnt  out  CNT_W each  load-use / mem-wait stall cycles

Function
REQ-006 Match(p, s) SHALL be p_regwrite & (p_rd != 0) & (p_rd == id_src[s]) & id_src_vld[s].
REQ-007 Per source s, the next select SHALL be 2'b10 if Match(idex, s), else 2'b01 if Match(exmem, s), else 2'b00; ID/EX has priority over EX/MEM.
REQ-008 fwd_sel SHALL register the next select on each clk edge: it holds while freeze=1, loads all-zero while flush_idex=1, and otherwise loads the computed value, so the select is valid in the cycle the instruction occupies EX.
REQ-009 load_use SHALL be idex_memread & Match(idex, s) for any s, excluding s=1 when id_is_store=1; that case is served by fwd_mem and SHALL NOT stall.
REQ-010 fwd_mem SHALL be combinational: memwb_regwrite & exmem_memwrite & (memwb_rd != 0) & (memwb_rd == exmem_rt).
REQ-011 The FSM SHALL have states RUN, LU_STALL and MEM_WAIT.
REQ-012 From RUN: if mem_busy, go to MEM_WAIT; else if load_use, go to LU_STALL; else stay in RUN.
REQ-013 LU_STALL SHALL last exactly one cycle and then go to MEM_WAIT if mem_busy, else to RUN; load_use is not re-detected because the load has moved to EX/MEM.
REQ-014 MEM_WAIT SHALL stay while mem_busy=1 and go to RUN when mem_busy=0.
REQ-015 freeze SHALL equal mem_busy, combinationally and in every state.
REQ-016 stall_fd and flush_idex SHALL equal load_use & ~mem_busy, combinationally.
REQ-017 mem_busy SHALL have priority over load_use when both are asserted; because inputs are frozen, load_use is re-evaluated after the freeze.
REQ-018 lu_cnt SHALL increment on every cycle where stall_fd=1.
REQ-019 mw_cnt SHALL increment on every cycle where freeze=1.
REQ-020 Both counters SHALL saturate at all-ones and not wrap.
REQ-021 cnt_clr SHALL zero both counters on the next edge and wins over a simultaneous increment.
REQ-022 Register 0 SHALL never match any producer.
REQ-023 A write to the register file from MEM/WB in the decode cycle is bypassed inside the register file and SHALL NOT generate a select.

Reset
REQ-024 On rst_n=0, asynchronously: state = RUN, fwd_sel = 0, lu_cnt = 0, mw_cnt = 0.
REQ-025 Combinational outputs SHALL follow their inputs during reset.
REQ-026 Reset asserted mid-stall or mid-freeze SHALL abandon the stall, with no residual effect after release.

Structure
REQ-027 Package hazard_pkg SHALL hold:
- the state enum (RUN, LU_STALL, MEM_WAIT)
- FWD_NONE = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10
REQ-028 One sub-module, fwd_src_cmp, SHALL compute the next select and the load-use hit for a single source; it is instantiated NUM_SRC times via generate.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Back-to-back ALU dependency: idex_rd=3 with regwrite, id_src[0]=3 -> next cycle fwd_sel[1:0]=10, no stall.
- Two-ago dependency: exmem_rd=5 and idex_rd=5 both writing, id_src[1]=5 -> fwd_sel[3:2]=10 (priority). With idex_regwrite=0 -> 01.
- Load-use: idex_memread=1, idex_rd=4, id_src[0]=4 -> stall_fd=flush_idex=1 for exactly one cycle, state RUN->LU_STALL->RUN, lu_cnt +1. Next cycle fwd_sel[1:0]=01.
- Load-then-store data: same as above but s=1 and id_is_store=1 -> no stall. Later memwb_rd=4, exmem_rt=4, exmem_memwrite=1 -> fwd_mem=1.
- mem_busy for 3 cycles coinciding with load_use -> freeze=1 for 3 cycles, stall_fd=0, fwd_sel held, mw_cnt=3. Then a one-cycle load-use stall follows.
- Counter saturation with CNT_W=2 -> lu_cnt stops at 3. cnt_clr together with an increment -> 0. rst_n pulse in MEM_WAIT -> state RUN, outputs zero.
